i2c_slave_mem: RTL and testbench
================================

Name: i2c_slave_mem

Overview:
Synthesisable, parametrised I2C slave with a small register memory. It runs synchronously on the core clock and oversamples SCL/SDA through a glitch filter. It is the RTL successor to the behavioural slave model: configurable device address, memory depth and filter length, plus a host-side write-notify port. It sits on the shared SCL/SDA pads next to i2c_master_top, both for loopback benches and for on-chip register access.

Parameters:
I2C_ADR, 7'b1010_000, 7-bit device address.
MEM_DEPTH, 4, number of bytes in memory (1..256).
FILTER, 3, consecutive identical samples needed to accept a new SCL/SDA level (1..15).

Ports:
wb_clk_i  in  1  core clock; all logic on the rising edge.
arst_i  in  1  asynchronous active-low reset.
scl_pad_i  in  1  SCL line.
sda_pad_i  in  1  SDA line.
sda_pad_o  out  1  SDA output value; constant 0.
sda_padoen_o  out  1  SDA output enable, active-low (0 = drive low, 1 = release).
busy_o  out  1  high from START to STOP.
wr_stb_o  out  1  one-cycle pulse per byte written to memory.
wr_adr_o  out  8  memory address of the write.
wr_dat_o  out  8  data written.

Behaviour:
- Reset (arst_i=0, asynchronous): sda_padoen_o=1, busy_o=0, wr_stb_o=0, wr_adr_o=0, wr_dat_o=0, memory all 0x00, pointer 0, state IDLE.
- Input path: 2-flop synchroniser, then FILTER-sample filter. Edge and START/STOP detection use the filtered levels only.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Latency from pad to filtered edge is 2+FILTER clocks.
- Timing rules:
  - Bits are sampled on filtered SCL rise.
  - The slave changes sda_padoen_o only on the clock after a filtered SCL fall, never while SCL is high.
- States: IDLE, DEV_ADR, DEV_ACK, MEM_ADR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - START or repeated START from any state: go to DEV_ADR, clear bit counter, set busy_o=1.
  - STOP from any state: go to IDLE, release SDA, busy_o=0. The pointer is retained.
  - DEV_ADR: shift 8 bits, MSB first.
    - If bits[7:1] match I2C_ADR: go to DEV_ACK and drive ACK (SDA low) for the 9th clock.
    - Then if R/W=0, go to MEM_ADR. If R/W=1, go to RD_DATA and load shift register from mem[pointer].
    - On mismatch: release SDA (NACK) and go to IDLE until the next START.
  - MEM_ADR: receive 8 bits.
    - If value < MEM_DEPTH: ACK, pointer = value, go to WR_DATA.
    - Otherwise: NACK, pointer unchanged, go to IDLE.
  - WR_DATA: after the 8th bit, write mem[pointer], pulse wr_stb_o with wr_adr_o/wr_dat_o, ACK, pointer = (pointer+1) mod MEM_DEPTH, return to WR_DATA. The data ACK is unconditional.
  - RD_DATA: drive data MSB first; a 1 bit is a release. Release SDA after the 8th bit and sample master ACK on the 9th SCL rise.
    - ACK (0): pointer+1 mod MEM_DEPTH, reload, continue RD_DATA.
    - NACK (1): go to IDLE and wait for STOP or START.
- Wrap: a pointer at MEM_DEPTH-1 increments to 0.
- Simultaneous events: START/STOP detection overrides bit sampling in the same cycle.
- A STOP in the middle of a byte discards the partial byte; no write occurs.
- Reset mid-transfer releases SDA immediately (combinationally via the async reset).

Optional Feature:
Macro I2CS_GENCALL_EN.
- Defined: address byte 0x00 (general call, write) is ACKed. Following data bytes are ACKed, are not written to memory, and each pulses wr_stb_o with wr_adr_o=8'hFF.
- Undefined: 0x00 is treated as a non-matching address and gets a NACK.

Test Plan:
- Write A0,01,A5,5A then STOP, all with defaults -> four ACKs; wr_stb_o pulses with (01,A5) and (02,5A); mem[1]=A5, mem[2]=5A.
- Write A0,00, repeated START, A1, read 4 bytes (ACK,ACK,ACK,NACK) -> read data 00,A5,5A,00; SDA released after the final byte.
- Write A0,10 (0x10 >= MEM_DEPTH) -> address ACK then NACK; no wr_stb_o; memory unchanged.
- Write device address A2 -> NACK on the 9th clock; bus ignored until the next START; busy_o stays 1 until STOP.
- Write A0,03,11,22 -> mem[3]=11, mem[0]=22 (wrap); then a 1-clock SDA glitch while SCL is high with FILTER=3 -> no START/STOP detected.
- arst_i pulsed low during RD_DATA while driving 0 -> sda_padoen_o=1 with no clock edge; busy_o=0; mem reads back 00.

Source files
------------

// File: rtl/i2c_slave_mem.sv
// I2C slave with a small register memory, oversampled through a synchroniser and glitch filter.
// Optional general-call support is enabled with `define I2CS_GENCALL_EN.
module i2c_slave_mem #(
  parameter logic [6:0]  I2C_ADR   = 7'b101_0000,
  parameter int unsigned MEM_DEPTH = 4,
  parameter int unsigned FILTER    = 3
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       busy_o,
  output logic       wr_stb_o,
  output logic [7:0] wr_adr_o,
  output logic [7:0] wr_dat_o
);

  localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  CNT_MAX = 4'(FILTER - 1);
  localparam logic [8:0]  DEPTH9  = 9'(MEM_DEPTH);
`ifdef I2CS_GENCALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, DEV_ADR, DEV_ACK, MEM_ADR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]      s1_q, s2_q, f_q, f_d, fp_q;
  logic [1:0][3:0] cnt_q, cnt_d;

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic            rw_q, rw_d;
  logic            gc_q, gc_d;
  logic            ack_drv_q, ack_drv_d;
  logic [AW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic            oen_q, oen_d;
  logic            busy_q, busy_d;
  logic            wr_stb_q, wr_stb_d;
  logic [7:0]      wr_adr_q, wr_adr_d;
  logic [7:0]      wr_dat_q, wr_dat_d;
  logic [7:0]      mem_q [MEM_DEPTH];
  logic            mem_we;
  logic [7:0]      mem_rd;
  logic [7:0]      byte_in;
  logic            scl_rise, scl_fall, start_det, stop_det;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      f_d[i]   = f_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] == CNT_MAX) f_d[i] = s2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  assign scl_rise  =  f_q[0] & ~fp_q[0];
  assign scl_fall  = ~f_q[0] &  fp_q[0];
  assign start_det = ~f_q[1] &  fp_q[1] & f_q[0];
  assign stop_det  =  f_q[1] & ~fp_q[1] & f_q[0];

  assign byte_in = {sr_q[6:0], f_q[1]};
  assign mem_rd  = mem_q[ptr_q];
  assign ptr_inc = (ptr_q == AW'(MEM_DEPTH - 1)) ? '0 : ptr_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    rw_d      = rw_q;
    gc_d      = gc_q;
    ack_drv_d = ack_drv_q;
    ptr_d     = ptr_q;
    oen_d     = oen_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_dat_d  = wr_dat_q;
    mem_we    = 1'b0;
    if (start_det) begin
      state_d   = DEV_ADR;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      ack_drv_d = 1'b0;
      gc_d      = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      oen_d     = 1'b1;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      unique case (state_q)
        DEV_ADR, MEM_ADR, WR_DATA: begin
          if (scl_fall) oen_d = 1'b1;
          if (scl_rise) begin
            sr_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == DEV_ADR) begin
                rw_d = byte_in[0];
                if (byte_in[7:1] == I2C_ADR) begin
                  state_d = DEV_ACK;
                end else if (GC_EN && byte_in == 8'h00) begin
                  state_d = DEV_ACK;
                  gc_d    = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end else if (state_q == MEM_ADR) begin
                if ({1'b0, byte_in} < DEPTH9) begin
                  ptr_d   = byte_in[AW-1:0];
                  state_d = MEM_ACK;
                end else begin
                  state_d = IDLE;
                end
              end else begin
                wr_stb_d = 1'b1;
                wr_dat_d = byte_in;
                state_d  = WR_ACK;
                if (gc_q) begin
                  wr_adr_d = 8'hFF;
                end else begin
                  mem_we   = 1'b1;
                  wr_adr_d = 8'(ptr_q);
                  ptr_d    = ptr_inc;
                end
              end
            end
          end
        end
        // ACK is driven on the first fall after the byte and released on the next.
        DEV_ACK, MEM_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              oen_d     = 1'b0;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              bit_cnt_d = '0;
              oen_d     = 1'b1;
              if (state_q == DEV_ACK && rw_q) begin
                state_d = RD_DATA;
                oen_d   = mem_rd[7];
                sr_d    = {mem_rd[6:0], 1'b0};
              end else if (state_q == DEV_ACK && !gc_q) begin
                state_d = MEM_ADR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oen_d = mem_rd[7];
              sr_d  = {mem_rd[6:0], 1'b0};
            end else begin
              oen_d = sr_q[7];
              sr_d  = {sr_q[6:0], 1'b0};
            end
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end
          end
        end
        RD_ACK: begin
          if (scl_fall) oen_d = 1'b1;
          if (scl_rise) begin
            if (!f_q[1]) begin
              ptr_d   = ptr_inc;
              state_d = RD_DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        IDLE: begin
          oen_d = oen_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      s1_q      <= '1;
      s2_q      <= '1;
      f_q       <= '1;
      fp_q      <= '1;
      cnt_q     <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      rw_q      <= 1'b0;
      gc_q      <= 1'b0;
      ack_drv_q <= 1'b0;
      ptr_q     <= '0;
      oen_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      s1_q      <= {sda_pad_i, scl_pad_i};
      s2_q      <= s1_q;
      f_q       <= f_d;
      fp_q      <= f_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      gc_q      <= gc_d;
      ack_drv_q <= ack_drv_d;
      ptr_q     <= ptr_d;
      oen_q     <= oen_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_adr_q  <= wr_adr_d;
      wr_dat_q  <= wr_dat_d;
      if (mem_we) mem_q[ptr_q] <= byte_in;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign busy_o       = busy_q;
  assign wr_stb_o     = wr_stb_q;
  assign wr_adr_o     = wr_adr_q;
  assign wr_dat_o     = wr_dat_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: table of bus operations plus glitch and async-reset sequences.
module tb_i2c_slave_mem;

  localparam int unsigned Q = 12;

  typedef enum logic [2:0] {OP_START, OP_RSTART, OP_STOP, OP_WR, OP_RD, OP_STB, OP_NOSTB, OP_BUSY} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_pad_o, sda_padoen_o, busy_o, wr_stb_o;
  logic [7:0] wr_adr_o, wr_dat_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] stbq[$];
  vec_t        vecs[$];

  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_slave_mem dut (
    .wb_clk_i     (clk),
    .arst_i       (arst_n),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .busy_o       (busy_o),
    .wr_stb_o     (wr_stb_o),
    .wr_adr_o     (wr_adr_o),
    .wr_dat_o     (wr_dat_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_stb_o === 1'b1) stbq.push_back({wr_adr_o, wr_dat_o});
  end

  task automatic wt(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bit_x(input logic b, output logic r);
    wt(Q); sda_m = b;
    wt(Q); scl_m = 1'b1;
    wt(Q); r = sda_line;
    wt(Q); scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int unsigned i = 0; i < 8; i++) bit_x(d[7-i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bit_x(1'b1, r);
      d = {d[6:0], r};
    end
    bit_x(mack, r);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; wt(2*Q);
    sda_m = 1'b0; wt(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic bus_rstart();
    wt(Q); sda_m = 1'b1;
    wt(Q); scl_m = 1'b1;
    wt(2*Q); sda_m = 1'b0;
    wt(2*Q); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wt(Q); sda_m = 1'b0;
    wt(Q); scl_m = 1'b1;
    wt(2*Q); sda_m = 1'b1;
    wt(2*Q);
  endtask

  function automatic void add(input op_e op, input logic [7:0] dat, input logic [7:0] exp);
    vec_t v;
    v.op = op; v.dat = dat; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [15:0] s;

    arst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wt(5);
    chk("rst_oen", {15'd0, sda_padoen_o}, 16'd1);
    chk("rst_busy", {15'd0, busy_o}, 16'd0);
    chk("rst_stb", {15'd0, wr_stb_o}, 16'd0);
    chk("rst_adr_dat", {wr_adr_o, wr_dat_o}, 16'h0000);
    chk("sda_pad_o", {15'd0, sda_pad_o}, 16'd0);
    arst_n = 1'b1;
    wt(10);

    // Write 01<-A5, 02<-5A
    add(OP_START, 8'h00, 8'h00); add(OP_BUSY, 8'h00, 8'h01);
    add(OP_WR, 8'hA0, 8'h00); add(OP_WR, 8'h01, 8'h00);
    add(OP_WR, 8'hA5, 8'h00); add(OP_WR, 8'h5A, 8'h00);
    add(OP_STB, 8'h01, 8'hA5); add(OP_STB, 8'h02, 8'h5A);
    add(OP_STOP, 8'h00, 8'h00); add(OP_BUSY, 8'h00, 8'h00);
    // Set pointer 0, repeated start, read four bytes
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA0, 8'h00); add(OP_WR, 8'h00, 8'h00);
    add(OP_RSTART, 8'h00, 8'h00); add(OP_WR, 8'hA1, 8'h00);
    add(OP_RD, 8'h00, 8'h00); add(OP_RD, 8'h00, 8'hA5);
    add(OP_RD, 8'h00, 8'h5A); add(OP_RD, 8'h01, 8'h00);
    add(OP_NOSTB, 8'h00, 8'h00); add(OP_STOP, 8'h00, 8'h00);
    // Out-of-range memory address
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA0, 8'h00); add(OP_WR, 8'h10, 8'h01);
    add(OP_NOSTB, 8'h00, 8'h00); add(OP_STOP, 8'h00, 8'h00);
    // Wrong device address: ignored until STOP
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA2, 8'h01); add(OP_WR, 8'h55, 8'h01);
    add(OP_BUSY, 8'h00, 8'h01); add(OP_NOSTB, 8'h00, 8'h00);
    add(OP_STOP, 8'h00, 8'h00); add(OP_BUSY, 8'h00, 8'h00);
    // Pointer wrap 3 -> 0
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA0, 8'h00); add(OP_WR, 8'h03, 8'h00);
    add(OP_WR, 8'h11, 8'h00); add(OP_WR, 8'h22, 8'h00);
    add(OP_STB, 8'h03, 8'h11); add(OP_STB, 8'h00, 8'h22);
    add(OP_STOP, 8'h00, 8'h00);
    // Read back whole memory
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA0, 8'h00); add(OP_WR, 8'h00, 8'h00);
    add(OP_RSTART, 8'h00, 8'h00); add(OP_WR, 8'hA1, 8'h00);
    add(OP_RD, 8'h00, 8'h22); add(OP_RD, 8'h00, 8'hA5);
    add(OP_RD, 8'h00, 8'h5A); add(OP_RD, 8'h01, 8'h11);
    add(OP_STOP, 8'h00, 8'h00);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_START:  bus_start();
        OP_RSTART: bus_rstart();
        OP_STOP:   bus_stop();
        OP_WR: begin
          wr_byte(vecs[i].dat, ack);
          chk($sformatf("ack[%0d]", i), {15'd0, ack}, {8'd0, vecs[i].exp});
        end
        OP_RD: begin
          rd_byte(vecs[i].dat[0], d);
          chk($sformatf("rdata[%0d]", i), {8'd0, d}, {8'd0, vecs[i].exp});
          if (vecs[i].dat[0]) begin
            wt(Q);
            chk($sformatf("rd_release[%0d]", i), {15'd0, sda_padoen_o}, 16'd1);
          end
        end
        OP_STB: begin
          s = (stbq.size() != 0) ? stbq.pop_front() : 16'hxxxx;
          chk($sformatf("wr_stb[%0d]", i), s, {vecs[i].dat, vecs[i].exp});
        end
        OP_NOSTB: chk($sformatf("no_stb[%0d]", i), 16'(stbq.size()), 16'd0);
        OP_BUSY:  chk($sformatf("busy[%0d]", i), {15'd0, busy_o}, {8'd0, vecs[i].exp});
        default: ;
      endcase
    end

    // Single-clock SDA glitches while SCL is high must not register as START or STOP
    sda_m = 1'b0; wt(1); sda_m = 1'b1; wt(20);
    chk("glitch_no_start", {15'd0, busy_o}, 16'd0);
    sda_m = 1'b0; wt(2*Q);
    chk("real_start", {15'd0, busy_o}, 16'd1);
    sda_m = 1'b1; wt(1); sda_m = 1'b0; wt(2*Q);
    chk("glitch_no_stop", {15'd0, busy_o}, 16'd1);
    scl_m = 1'b0;
    bus_stop();
    chk("stop_after_glitch", {15'd0, busy_o}, 16'd0);

    // Async reset while the slave drives a 0 data bit
    bus_start(); wr_byte(8'hA0, ack); wr_byte(8'h00, ack);
    bus_rstart(); wr_byte(8'hA1, ack);
    chk("rd_addr_ack", {15'd0, ack}, 16'd0);
    wt(Q);
    chk("driving_zero", {15'd0, sda_padoen_o}, 16'd0);
    #2 arst_n = 1'b0;
    #1;
    chk("async_rst_oen", {15'd0, sda_padoen_o}, 16'd1);
    chk("async_rst_busy", {15'd0, busy_o}, 16'd0);
    wt(3);
    arst_n = 1'b1;
    sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(4*Q);
    bus_start(); wr_byte(8'hA0, ack); wr_byte(8'h00, ack);
    bus_rstart(); wr_byte(8'hA1, ack);
    for (int unsigned i = 0; i < 4; i++) begin
      rd_byte(i == 3, d);
      chk($sformatf("post_rst_mem[%0d]", i), {8'd0, d}, 16'h0000);
    end
    bus_stop();
    chk("post_rst_no_stb", 16'(stbq.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
